// File: rtl/dsm_seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// dsm_pkg
// Shared types and constants for the MASH 1-1-1 sequencing controller.
//   dsm_state_t : controller FSM states
//   dsm_dbg_t   : debug view of the controller (state, settle count, shadow restart)
//   LFSR_SEED   : dither LFSR seed (never all-zero)
//   LFSR_TAPS   : feedback taps for x^15 + x^14 + 1 (register bits 14 and 13)
//   DSM_FRAC_W  : default fractional word width
// -----------------------------------------------------------------------------
package dsm_pkg;

   localparam int          DSM_FRAC_W = 16;
   localparam logic [14:0] LFSR_SEED  = 15'h0001;
   localparam logic [14:0] LFSR_TAPS  = 15'h6000;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CLEAR  = 2'd1,
      ST_SETTLE = 2'd2,
      ST_RUN    = 2'd3
   } dsm_state_t;

   typedef struct packed {
      dsm_state_t  state;
      logic [3:0]  settle_cnt;
      logic        shadow_restart;
   } dsm_dbg_t;

endpackage

// File: rtl/dsm_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// dsm_seq_ctrl_if
// Configuration channel from the PLL register block to the sequencer.
//
// Handshake: a transfer happens on a rising clk edge where cfg_valid and
// cfg_ready are both 1. While cfg_valid is 1 and cfg_ready is 0 the source
// holds cfg_frac/cfg_restart/cfg_dither_en stable; cfg_ready never depends
// combinationally on cfg_valid.
//
//   cfg_valid     : source -> controller, offer present
//   cfg_ready     : controller -> source, offer may be taken this edge
//   cfg_frac      : new fractional word
//   cfg_restart   : 1 = apply through clear/settle, 0 = seamless update
//   cfg_dither_en : enable LSB dither
// -----------------------------------------------------------------------------
interface dsm_seq_ctrl_if #(
   parameter int FRAC_W = 16
);
   logic              cfg_valid;
   logic              cfg_ready;
   logic [FRAC_W-1:0] cfg_frac;
   logic              cfg_restart;
   logic              cfg_dither_en;

   modport master (
      output cfg_valid,
      output cfg_frac,
      output cfg_restart,
      output cfg_dither_en,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid,
      input  cfg_frac,
      input  cfg_restart,
      input  cfg_dither_en,
      output cfg_ready
   );
endinterface

// File: rtl/dsm_seq_ctrl_lfsr.sv
// -----------------------------------------------------------------------------
// dsm_dither_lfsr
// 15-bit Fibonacci LFSR (x^15 + x^14 + 1) supplying one dither bit per cycle.
//   clk       : clock
//   rst_n     : asynchronous active-low reset, loads LFSR_SEED
//   adv       : shift one step this cycle
//   seed_load : reload LFSR_SEED (wins over adv)
//   bit_out   : current dither bit (register bit 0)
// The polynomial is primitive and the seed is nonzero, so the register cycles
// through all 2^15-1 nonzero states and never locks up at zero.
// -----------------------------------------------------------------------------
module dsm_dither_lfsr
   import dsm_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic adv,
   input  logic seed_load,
   output logic bit_out
);

   logic [14:0] lfsr_q;
   logic [14:0] lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (seed_load) begin
         lfsr_d = LFSR_SEED;
      end else if (adv) begin
         lfsr_d = {lfsr_q[13:0], ^(lfsr_q & LFSR_TAPS)};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_q <= LFSR_SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign bit_out = lfsr_q[0];

endmodule

// File: rtl/dsm_seq_ctrl.sv
// -----------------------------------------------------------------------------
// dsm_seq_ctrl
// Sequencing/configuration controller for the MASH 1-1-1 modulator and its
// noise shaper. Takes fractional-word updates over the cfg channel, applies
// them seamlessly or through a clear/settle restart, gates the datapath and
// masks the shaper output until the pipeline has settled.
//
//   clk        : clock
//   rst_n      : asynchronous active-low reset
//   enable     : 1 = modulator runs, 0 = stopped (overrides everything)
//   cfg        : configuration channel (slave side)
//   mash_frac  : fractional word to MASH stage 1, dither in bit 0
//   mash_en    : clock-enable of MASH accumulators and shaper registers
//   mash_clr   : one-cycle synchronous clear of accumulators/delay lines
//   out_valid  : shaper output may be consumed
//   busy       : clearing or settling
//   dbg        : FSM state, settle counter and shadow restart bit
//
// Every output is a register or a decode of the state register; no input
// reaches an output combinationally.
// -----------------------------------------------------------------------------
module dsm_seq_ctrl
   import dsm_pkg::*;
#(
   parameter int FRAC_W     = DSM_FRAC_W,
   parameter int SETTLE_CYC = 4             // legal range 1..15
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   dsm_seq_ctrl_if.slave     cfg,
   output logic [FRAC_W-1:0] mash_frac,
   output logic              mash_en,
   output logic              mash_clr,
   output logic              out_valid,
   output logic              busy,
   output dsm_dbg_t          dbg
);

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

   dsm_state_t        state_q,     state_d;
   logic [3:0]        cnt_q,       cnt_d;
   logic [FRAC_W-1:0] sh_frac_q,   sh_frac_d;
   logic              sh_dith_q,   sh_dith_d;
   logic              sh_rst_q,    sh_rst_d;
   logic [FRAC_W-1:0] frac_q,      frac_d;
   logic              dith_q,      dith_d;
   logic              upd_q,       upd_d;

   logic              ready;
   logic              hs;
   logic              lfsr_bit;

   // Output decode straight from the state register.
   assign ready     = (state_q == ST_IDLE) || (state_q == ST_RUN);
   assign mash_clr  = (state_q == ST_CLEAR);
   assign mash_en   = (state_q == ST_SETTLE) || (state_q == ST_RUN);
   assign out_valid = (state_q == ST_RUN);
   assign busy      = (state_q == ST_CLEAR) || (state_q == ST_SETTLE);

   assign cfg.cfg_ready = ready;
   assign hs            = cfg.cfg_valid && ready;

   // ---------------- FSM next state + settle counter ----------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (enable) state_d = ST_CLEAR;
         end
         ST_CLEAR: begin
            cnt_d   = '0;
            state_d = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (cnt_q == SETTLE_LAST) begin
               state_d = ST_RUN;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_RUN: begin
            if (hs && cfg.cfg_restart) state_d = ST_CLEAR;
         end
         default: state_d = ST_IDLE;
      endcase
      // Stopping wins over every other transition.
      if (!enable) state_d = ST_IDLE;
   end

   // ---------------- shadow and applied word ----------------
   always_comb begin
      sh_frac_d = sh_frac_q;
      sh_dith_d = sh_dith_q;
      sh_rst_d  = sh_rst_q;
      frac_d    = frac_q;
      dith_d    = dith_q;

      // The shadow captures every accepted offer, even one that coincides
      // with enable dropping, so the next start applies it.
      if (hs) begin
         sh_frac_d = cfg.cfg_frac;
         sh_dith_d = cfg.cfg_dither_en;
         sh_rst_d  = cfg.cfg_restart;
      end

      // Seamless updates go through the shadow, hence one cycle after the
      // handshake; restarts pick the shadow up while clearing.
      if ((state_q == ST_CLEAR) || upd_q) begin
         frac_d = sh_frac_q;
         dith_d = sh_dith_q;
      end

      upd_d = (state_q == ST_RUN) && enable && hs && !cfg.cfg_restart;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         sh_frac_q <= '0;
         sh_dith_q <= 1'b0;
         sh_rst_q  <= 1'b0;
         frac_q    <= '0;
         dith_q    <= 1'b0;
         upd_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         sh_frac_q <= sh_frac_d;
         sh_dith_q <= sh_dith_d;
         sh_rst_q  <= sh_rst_d;
         frac_q    <= frac_d;
         dith_q    <= dith_d;
         upd_q     <= upd_d;
      end
   end

   // ---------------- dither ----------------
   // The LFSR runs with the datapath and restarts with it, so a given
   // configuration always produces the same dither sequence after a clear.
   dsm_dither_lfsr u_lfsr (
      .clk       (clk),
      .rst_n     (rst_n),
      .adv       (mash_en),
      .seed_load (mash_clr),
      .bit_out   (lfsr_bit)
   );

   assign mash_frac = frac_q ^ {{(FRAC_W-1){1'b0}}, dith_q & lfsr_bit};

   assign dbg.state          = state_q;
   assign dbg.settle_cnt     = cnt_q;
   assign dbg.shadow_restart = sh_rst_q;

endmodule

// File: tb/tb_dsm_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dsm_seq_ctrl
// Directed and randomized bench for dsm_seq_ctrl. The reference model tracks
// "cycles since the last clear" rather than FSM states, and the dither as a
// plain integer LFSR.
// -----------------------------------------------------------------------------
module tb_dsm_seq_ctrl;
  import dsm_pkg::*;

  localparam int FRAC_W     = 16;
  localparam int SETTLE_CYC = 4;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  always #5 clk = ~clk;

  logic [FRAC_W-1:0] mash_frac;
  logic              mash_en;
  logic              mash_clr;
  logic              out_valid;
  logic              busy;
  dsm_dbg_t          dbg;

  dsm_seq_ctrl_if #(.FRAC_W(FRAC_W)) cfg_if ();

  dsm_seq_ctrl #(.FRAC_W(FRAC_W), .SETTLE_CYC(SETTLE_CYC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .cfg       (cfg_if),
    .mash_frac (mash_frac),
    .mash_en   (mash_en),
    .mash_clr  (mash_clr),
    .out_valid (out_valid),
    .busy      (busy),
    .dbg       (dbg)
  );

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  bit                m_run;       // modulator started (not stopped)
  int                m_sc;        // cycles since the cycle carrying mash_clr
  logic [FRAC_W-1:0] m_sh_frac;
  bit                m_sh_dith;
  logic [FRAC_W-1:0] m_frac;
  bit                m_dith;
  bit                m_pend;
  int                m_lfsr;
  bit                m_last_hs;

  function automatic int lfsr_next(input int x);
    return ((x * 2) % 32768) + (((x / 16384) + (x / 8192)) % 2);
  endfunction

  function automatic bit exp_clr();   return m_run && (m_sc == 0);               endfunction
  function automatic bit exp_en();    return m_run && (m_sc >= 1);               endfunction
  function automatic bit exp_ov();    return m_run && (m_sc >= SETTLE_CYC + 1);  endfunction
  function automatic bit exp_busy();  return m_run && (m_sc <= SETTLE_CYC);      endfunction
  function automatic bit exp_rdy();   return !m_run || exp_ov();                 endfunction
  function automatic logic [FRAC_W-1:0] exp_frac();
    logic [FRAC_W-1:0] f;
    f = m_frac;
    if (m_dith && (m_lfsr % 2 == 1)) f[0] = ~f[0];
    return f;
  endfunction

  task automatic model_reset();
    m_run = 0; m_sc = 0; m_sh_frac = '0; m_sh_dith = 0;
    m_frac = '0; m_dith = 0; m_pend = 0; m_lfsr = 1; m_last_hs = 0;
  endtask

  task automatic model_edge();
    bit clr_o, en_o, ov_o, hs;
    clr_o = exp_clr();
    en_o  = exp_en();
    ov_o  = exp_ov();
    hs    = cfg_if.cfg_valid && exp_rdy();
    m_last_hs = hs;
    if (clr_o || m_pend) begin
      m_frac = m_sh_frac;
      m_dith = m_sh_dith;
    end
    m_pend = ov_o && enable && hs && !cfg_if.cfg_restart;
    if (clr_o) m_lfsr = 1;
    else if (en_o) m_lfsr = lfsr_next(m_lfsr);
    if (!m_run) begin
      if (enable) begin m_run = 1; m_sc = 0; end
    end else if (!enable) begin
      m_run = 0;
    end else if (ov_o && hs && cfg_if.cfg_restart) begin
      m_sc = 0;
    end else if (m_sc <= SETTLE_CYC) begin
      m_sc++;
    end
    if (hs) begin
      m_sh_frac = cfg_if.cfg_frac;
      m_sh_dith = cfg_if.cfg_dither_en;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string ctx);
    chk({ctx, ".mash_frac"}, 32'(mash_frac), 32'(exp_frac()));
    chk({ctx, ".mash_en"},   32'(mash_en),   32'(exp_en()));
    chk({ctx, ".mash_clr"},  32'(mash_clr),  32'(exp_clr()));
    chk({ctx, ".out_valid"}, 32'(out_valid), 32'(exp_ov()));
    chk({ctx, ".busy"},      32'(busy),      32'(exp_busy()));
    chk({ctx, ".cfg_ready"}, 32'(cfg_if.cfg_ready), 32'(exp_rdy()));
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input string ctx);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs(ctx);
  endtask

  task automatic ticks(input string ctx, input int n);
    for (int i = 0; i < n; i++) tick(ctx);
  endtask

  // Offer a configuration and hold it until it is taken (bounded).
  task automatic offer(input string ctx, input logic [FRAC_W-1:0] f,
                       input bit rst, input bit dith);
    bit taken;
    taken = 0;
    cfg_if.cfg_valid     = 1'b1;
    cfg_if.cfg_frac      = f;
    cfg_if.cfg_restart   = rst;
    cfg_if.cfg_dither_en = dith;
    for (int i = 0; i < 64 && !taken; i++) begin
      tick(ctx);
      taken = m_last_hs;
    end
    chk({ctx, ".accepted"}, 32'(taken), 32'd1);
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic async_reset(input string ctx);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs({ctx, ".in_reset"});
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_outputs({ctx, ".released"});
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    cfg_if.cfg_valid     = 1'b0;
    cfg_if.cfg_frac      = '0;
    cfg_if.cfg_restart   = 1'b0;
    cfg_if.cfg_dither_en = 1'b0;
    model_reset();

    #3;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    ticks("idle", 3);

    // Start-up: clear at cycle 1, enable at 2, out_valid at 6.
    enable = 1'b1;
    ticks("start", 8);

    // Seamless update.
    offer("seamless", 16'h4000, 1'b0, 1'b0);
    ticks("seamless_after", 3);

    // Restart update, followed immediately by an offer that has to wait
    // through CLEAR/SETTLE and is taken on the first RUN cycle.
    offer("restart", 16'h1234, 1'b1, 1'b0);
    offer("held_offer", 16'h5555, 1'b0, 1'b0);
    ticks("held_after", 3);

    // Dither on a zero word; restart again to see the sequence restart.
    offer("dither", 16'h0000, 1'b1, 1'b1);
    ticks("dither_run", 40);
    offer("dither_re", 16'h0000, 1'b1, 1'b1);
    ticks("dither_rerun", 12);

    // Enable drops on the same edge as a restart handshake.
    cfg_if.cfg_valid     = 1'b1;
    cfg_if.cfg_frac      = 16'hABCD;
    cfg_if.cfg_restart   = 1'b1;
    cfg_if.cfg_dither_en = 1'b0;
    enable = 1'b0;
    tick("drop_hs");
    chk("drop_hs.taken", 32'(m_last_hs), 32'd1);
    cfg_if.cfg_valid = 1'b0;
    ticks("drop_idle", 3);
    enable = 1'b1;
    ticks("drop_restart", 8);

    // Asynchronous reset in the middle of SETTLE.
    offer("pre_areset", 16'h0F0F, 1'b1, 1'b1);
    ticks("settling", 2);
    async_reset("areset");
    ticks("after_areset", 8);

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      if (!cfg_if.cfg_valid && $urandom_range(0, 3) == 0) begin
        cfg_if.cfg_valid     = 1'b1;
        cfg_if.cfg_frac      = FRAC_W'($urandom);
        cfg_if.cfg_restart   = ($urandom_range(0, 4) == 0);
        cfg_if.cfg_dither_en = $urandom_range(0, 1) == 1;
      end
      enable = !(enable && $urandom_range(0, 39) == 0);
      tick("random");
      if (m_last_hs) cfg_if.cfg_valid = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
